// File: rtl/pci_rr_arbiter.sv
// Round-robin PCI bus arbiter with grant-hold preemption, a one-cycle dead
// turnaround between owners and optional parking on an idle bus.
module pci_rr_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int MAX_HOLD  = 16,
    parameter bit PARK_EN   = 1'b1,
    parameter int PARK_ID   = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [N_MASTERS-1:0]                      REQ,
    output logic [N_MASTERS-1:0]                      GNT,
    output logic [(N_MASTERS > 1 ? $clog2(N_MASTERS) : 1)-1:0] gnt_id,
    output logic                                      gnt_valid,
    output logic                                      parked
);
    localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [IDW-1:0] PARK_IDX = IDW'(PARK_ID);
    localparam logic [IDW-1:0] LAST_RST = IDW'(N_MASTERS - 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state;
    logic [IDW-1:0]  last;
    logic [HW-1:0]   hold_cnt;
    logic [IDW-1:0]  winner;
    logic            own_req;
    logic            other_req;
    logic            hold_left;

    // First requester at or after last+1, wrapping; the previous owner comes last.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [IDW-1:0] from);
        logic [IDW-1:0] pick;
        int             idx;
        pick = from;
        for (int i = N_MASTERS; i >= 1; i--) begin
            idx = (int'(from) + i) % N_MASTERS;
            if (req[idx]) pick = IDW'(idx);
        end
        return pick;
    endfunction

    assign winner    = rr_pick(REQ, last);
    assign own_req   = REQ[gnt_id];
    assign other_req = |(REQ & ~GNT);
    assign hold_left = (MAX_HOLD == 0) || (hold_cnt < HOLD_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            GNT       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            parked    <= 1'b0;
            last      <= LAST_RST;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (|REQ) begin
                        state     <= GRANT;
                        GNT       <= N_MASTERS'(1) << winner;
                        gnt_id    <= winner;
                        gnt_valid <= 1'b1;
                        parked    <= 1'b0;
                        last      <= winner;
                        hold_cnt  <= HW'(1);
                    end else if (PARK_EN) begin
                        state     <= GRANT;
                        GNT       <= N_MASTERS'(1) << PARK_IDX;
                        gnt_id    <= PARK_IDX;
                        gnt_valid <= 1'b1;
                        parked    <= 1'b1;
                        hold_cnt  <= HW'(1);
                    end else begin
                        state     <= IDLE;
                        GNT       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        parked    <= 1'b0;
                    end
                end
                GRANT: begin
                    if (parked) begin
                        // Parked owner asking for the bus keeps it without a gap.
                        if (own_req) begin
                            parked   <= 1'b0;
                            hold_cnt <= HW'(1);
                            last     <= gnt_id;
                        end else if (other_req) begin
                            state     <= TURN;
                            GNT       <= '0;
                            gnt_id    <= '0;
                            gnt_valid <= 1'b0;
                            parked    <= 1'b0;
                        end
                    end else if ((own_req && (!other_req || hold_left)) ||
                                 (!own_req && !other_req && PARK_EN && gnt_id == PARK_IDX)) begin
                        parked <= !own_req;
                        if (hold_left) hold_cnt <= hold_cnt + HW'(1);
                    end else begin
                        state     <= (!own_req && !other_req && !PARK_EN) ? IDLE : TURN;
                        GNT       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        parked    <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    GNT       <= '0;
                    gnt_id    <= '0;
                    gnt_valid <= 1'b0;
                    parked    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Self-checking bench for pci_rr_arbiter: directed scenarios plus randomized
// traffic compared against an owner/tenure reference model.
module tb_pci_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 4;
    localparam int PID = 0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] GNT;
    logic [1:0]   gnt_id;
    logic         gnt_valid;
    logic         parked;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner (-1 = bus dead/idle), park flag, tenure length, last winner.
    int m_owner, m_last, m_tenure;
    bit m_park;

    pci_rr_arbiter #(.N_MASTERS(N), .MAX_HOLD(MH), .PARK_EN(1'b1), .PARK_ID(PID)) dut (
        .clk(clk), .reset(reset), .REQ(REQ), .GNT(GNT),
        .gnt_id(gnt_id), .gnt_valid(gnt_valid), .parked(parked)
    );

    always #5 clk = ~clk;

    function automatic int rr_winner(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++)
            if (r[(from + k) % N]) return (from + k) % N;
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] others;
        if (rs) begin
            m_owner = -1; m_last = N - 1; m_park = 0; m_tenure = 0;
        end else if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = rr_winner(r, m_last); m_last = m_owner; m_park = 0; m_tenure = 1;
            end else begin
                m_owner = PID; m_park = 1; m_tenure = 1;
            end
        end else if (m_park) begin
            if (r[m_owner]) begin
                m_park = 0; m_tenure = 1; m_last = m_owner;
            end else if (r != 0) begin
                m_owner = -1; m_park = 0;
            end
        end else begin
            others = r & ~(N'(1) << m_owner);
            if (r[m_owner] && (others == 0 || m_tenure < MH)) m_tenure++;
            else if (!r[m_owner] && others == 0 && m_owner == PID) begin
                m_park = 1; m_tenure++;
            end else m_owner = -1;
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return (m_owner < 0) ? '0 : (N'(1) << m_owner);
    endfunction

    task automatic tick(input logic [N-1:0] r, input logic rs);
        REQ = r; reset = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
    endtask

    task automatic test_reset();
        tick('1, 1'b1);
        tick('1, 1'b1);
        vectors++;
        if (GNT !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0 || parked !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: gnt=%b id=%0d v=%b p=%b, want 0000/0/0/0", GNT, gnt_id, gnt_valid, parked);
        end
    endtask

    task automatic test_park_startup();
        tick('0, 1'b1);
        tick('0, 1'b0);
        vectors++;
        if (GNT !== 4'b0001 || gnt_id !== 2'd0 || gnt_valid !== 1'b1 || parked !== 1'b1) begin
            miscompares++;
            $display("FAIL park_startup: gnt=%b id=%0d v=%b p=%b, want 0001/0/1/1", GNT, gnt_id, gnt_valid, parked);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] want;
        tick('1, 1'b1);
        for (int i = 0; i < 25; i++) begin
            tick('1, 1'b0);
            want = (i % 5 < 4) ? (N'(1) << ((i / 5) % N)) : '0;
            vectors++;
            if (GNT !== want || gnt_valid !== (want != 0)) begin
                miscompares++;
                $display("FAIL rotation cyc %0d: gnt=%b v=%b, want %b", i, GNT, gnt_valid, want);
            end
        end
    endtask

    task automatic test_owner_switch();
        tick('0, 1'b1);
        tick(4'b0010, 1'b0);
        vectors++;
        if (GNT !== 4'b0010) begin
            miscompares++;
            $display("FAIL switch_setup: gnt=%b, want 0010", GNT);
        end
        tick(4'b1000, 1'b0);
        vectors++;
        if (GNT !== 4'b0000 || gnt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL switch_turn: gnt=%b v=%b, want 0000/0", GNT, gnt_valid);
        end
        tick(4'b1000, 1'b0);
        vectors++;
        if (GNT !== 4'b1000 || gnt_id !== 2'd3 || parked !== 1'b0) begin
            miscompares++;
            $display("FAIL switch_new: gnt=%b id=%0d p=%b, want 1000/3/0", GNT, gnt_id, parked);
        end
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        tick('0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick(4'b0100, 1'b0);
            if (GNT !== 4'b0100 || gnt_id !== 2'd2) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL saturation_hold: %0d cycles without GNT2, want 0", bad);
        end
        // Saturated counter means a new contender preempts on the very next edge.
        tick(4'b0101, 1'b0);
        vectors++;
        if (GNT !== 4'b0000) begin
            miscompares++;
            $display("FAIL saturation_preempt: gnt=%b, want 0000", GNT);
        end
        tick(4'b0101, 1'b0);
        vectors++;
        if (GNT !== 4'b0001 || parked !== 1'b0) begin
            miscompares++;
            $display("FAIL saturation_next: gnt=%b p=%b, want 0001/0", GNT, parked);
        end
    endtask

    task automatic test_park_handoff();
        tick('0, 1'b1);
        tick('0, 1'b0);
        tick(4'b0001, 1'b0);
        vectors++;
        if (GNT !== 4'b0001 || parked !== 1'b0 || gnt_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL park_claim: gnt=%b p=%b v=%b, want 0001/0/1", GNT, parked, gnt_valid);
        end
        tick(4'b0000, 1'b0);
        vectors++;
        if (GNT !== 4'b0001 || parked !== 1'b1) begin
            miscompares++;
            $display("FAIL park_return: gnt=%b p=%b, want 0001/1", GNT, parked);
        end
        tick(4'b0010, 1'b0);
        vectors++;
        if (GNT !== 4'b0000 || parked !== 1'b0) begin
            miscompares++;
            $display("FAIL park_leave_turn: gnt=%b p=%b, want 0000/0", GNT, parked);
        end
        tick(4'b0010, 1'b0);
        vectors++;
        if (GNT !== 4'b0010 || gnt_id !== 2'd1) begin
            miscompares++;
            $display("FAIL park_leave_grant: gnt=%b id=%0d, want 0010/1", GNT, gnt_id);
        end
    endtask

    task automatic test_reset_mid_grant();
        tick('1, 1'b1);
        for (int i = 0; i < 11; i++) tick('1, 1'b0);
        vectors++;
        if (GNT !== 4'b0100) begin
            miscompares++;
            $display("FAIL midreset_setup: gnt=%b, want 0100", GNT);
        end
        tick('1, 1'b1);
        vectors++;
        if (GNT !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0 || parked !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_clear: gnt=%b id=%0d v=%b p=%b, want 0000/0/0/0", GNT, gnt_id, gnt_valid, parked);
        end
        tick('1, 1'b0);
        vectors++;
        if (GNT !== 4'b0001 || gnt_id !== 2'd0) begin
            miscompares++;
            $display("FAIL midreset_first: gnt=%b id=%0d, want 0001/0", GNT, gnt_id);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r, prev_gnt, want;
        logic         rs;
        r = '0;
        tick('0, 1'b1);
        prev_gnt = GNT;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) r = N'($urandom);
            rs = ($urandom_range(99) == 0);
            tick(r, rs);
            want = exp_gnt();
            vectors++;
            if (GNT !== want || gnt_id !== ((m_owner < 0) ? 2'd0 : 2'(m_owner)) ||
                gnt_valid !== (m_owner >= 0) || parked !== m_park) begin
                miscompares++;
                $display("FAIL random cyc %0d req=%b: gnt=%b id=%0d v=%b p=%b, want gnt=%b p=%b",
                         i, r, GNT, gnt_id, gnt_valid, parked, want, m_park);
            end
            vectors++;
            if (prev_gnt != 0 && GNT != 0 && GNT !== prev_gnt) begin
                miscompares++;
                $display("FAIL no_turnaround cyc %0d: gnt %b -> %b, want a dead cycle", i, prev_gnt, GNT);
            end
            prev_gnt = GNT;
        end
    endtask

    initial begin
        m_owner = -1; m_last = N - 1; m_park = 0; m_tenure = 0;
        test_reset();
        test_park_startup();
        test_rotation();
        test_owner_switch();
        test_saturation();
        test_park_handoff();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
